ula_logic_seq: RTL and testbench

Byte-stream command sequencer that drives the ALU logic unit's operand and opcode inputs and returns the result. It accepts framed commands (header, A, optional B) on a valid/ready byte stream and holds the ALU inputs stable for one execute cycle. It captures the ALU logic output and presents it on a valid/ready result port. It sits between the host byte link and the logic unit, and flags malformed or stalled frames.

---
 rtl/ula_pkg.sv | 23 ++
 rtl/ula_logic_seq_timer.sv | 26 ++
 rtl/ula_logic_seq.sv | 140 ++++++++++++++
 tb/tb_ula_logic_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types and constants for the ALU logic-unit command sequencer.
package ula_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC,
        RESP
    } ula_seq_state_t;

    localparam logic [4:0] ULA_SYNC = 5'b10100;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_A    = 3'b111;

endpackage

// File: rtl/ula_logic_seq_timer.sv
// Inter-byte idle counter; holds at the limit until cleared.
module ula_idle_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] cnt;

    assign expired = (cnt == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ula_logic_seq.sv
// Framed byte-stream sequencer feeding the ALU logic unit and returning its result.
module ula_logic_seq
    import ula_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_out,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    ula_seq_state_t state, state_n;

    logic ld_op, ld_a, ld_b, clr_b, cap, err;
    logic in_frame, accept, expired;

    assign in_frame  = (state == GET_A) || (state == GET_B);
    assign accept    = in_valid && in_ready;
    assign res_valid = (state == RESP);

    ula_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept || !in_frame),
        .count_en(in_frame && !in_valid),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        ld_op    = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        clr_b    = 1'b0;
        cap      = 1'b0;
        err      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data[7:3] == ULA_SYNC) begin
                        ld_op   = 1'b1;
                        state_n = GET_A;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            GET_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_a = 1'b1;
                    if (alu_opcode[2:1] == OP_NOTA[2:1]) begin
                        clr_b   = 1'b1;
                        state_n = EXEC;
                    end else begin
                        state_n = GET_B;
                    end
                end else if (expired) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
            GET_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_b    = 1'b1;
                    state_n = EXEC;
                end else if (expired) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
            EXEC: begin
                cap     = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand registers only move on accepted bytes, so the ALU sees stable inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            res_data   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse <= err;
            if (err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (ld_op) begin
                alu_opcode <= in_data[2:0];
            end
            if (ld_a) begin
                alu_a <= in_data;
            end
            if (ld_b) begin
                alu_b <= in_data;
            end else if (clr_b) begin
                alu_b <= '0;
            end
            if (cap) begin
                res_data <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_ula_logic_seq.sv
// Directed self-checking bench for ula_logic_seq with a behavioural logic unit.
module tb_ula_logic_seq;

    localparam int TO = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic       err_pulse;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;

    ula_logic_seq #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opcode(alu_opcode),
        .alu_out   (alu_out),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic unit model
    logic [7:0] raw;
    always_comb begin
        raw = '0;
        case (alu_opcode[2:1])
            2'b00: raw = alu_a & alu_b;
            2'b01: raw = alu_a | alu_b;
            2'b10: raw = alu_a ^ alu_b;
            default: raw = ~alu_a;
        endcase
        alu_out = alu_opcode[0] ? ~raw : raw;
    end

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] a;
        logic [7:0] b;
        logic       two;
        logic [2:0] op;
        logic [7:0] exp_b;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=%h exp=%h", in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA0, 8'hF0, 8'h3C, 1'b0, 3'b000, 8'h3C, 8'h30};
        vecs[1] = '{8'hA1, 8'hF0, 8'h3C, 1'b0, 3'b001, 8'h3C, 8'hCF};
        vecs[2] = '{8'hA6, 8'h5A, 8'h00, 1'b1, 3'b110, 8'h00, 8'hA5};
        vecs[3] = '{8'hA7, 8'h5A, 8'h00, 1'b1, 3'b111, 8'h00, 8'h5A};
        vecs[4] = '{8'hA3, 8'h0F, 8'hF0, 1'b0, 3'b011, 8'hF0, 8'h00};
        vecs[5] = '{8'hA5, 8'hAA, 8'hAA, 1'b0, 3'b101, 8'hAA, 8'hFF};

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        #12;
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        chk("rst_res_valid", {7'd0, res_valid}, 8'h00);
        chk("rst_err_count", err_count, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].hdr);
            send(vecs[i].a);
            if (!vecs[i].two) send(vecs[i].b);
            chk("exec_res_valid", {7'd0, res_valid}, 8'h00);
            chk("exec_in_ready", {7'd0, in_ready}, 8'h00);
            @(posedge clk);
            #1;
            chk("res_valid", {7'd0, res_valid}, 8'h01);
            chk("res_data", res_data, vecs[i].exp_res);
            chk("alu_a", alu_a, vecs[i].a);
            chk("alu_b", alu_b, vecs[i].exp_b);
            chk("alu_opcode", {5'd0, alu_opcode}, {5'd0, vecs[i].op});
            @(posedge clk);
            #1;
            chk("back_idle", {7'd0, in_ready}, 8'h01);
        end

        // bad header
        send(8'h00);
        chk("bad_err_pulse", {7'd0, err_pulse}, 8'h01);
        chk("bad_err_count", err_count, 8'h01);
        chk("bad_no_result", {7'd0, res_valid}, 8'h00);
        chk("bad_in_ready", {7'd0, in_ready}, 8'h01);
        @(posedge clk);
        #1;
        chk("bad_pulse_end", {7'd0, err_pulse}, 8'h00);
        send(8'hA4);
        send(8'h0F);
        send(8'hFF);
        @(posedge clk);
        #1;
        chk("after_bad_res", res_data, 8'hF0);
        chk("after_bad_rv", {7'd0, res_valid}, 8'h01);
        @(posedge clk);
        #1;

        // timeout drop
        send(8'hA2);
        send(8'h11);
        repeat (TO) @(posedge clk);
        #1;
        chk("to_pre_pulse", {7'd0, err_pulse}, 8'h00);
        @(posedge clk);
        #1;
        chk("to_err_pulse", {7'd0, err_pulse}, 8'h01);
        chk("to_err_count", err_count, 8'h02);
        chk("to_no_result", {7'd0, res_valid}, 8'h00);
        chk("to_keep_a", alu_a, 8'h11);
        @(posedge clk);
        #1;
        chk("to_pulse_end", {7'd0, err_pulse}, 8'h00);

        // byte on the expiry cycle wins
        send(8'hA2);
        send(8'h11);
        repeat (TO) @(posedge clk);
        #1;
        send(8'h22);
        chk("race_exec", {7'd0, res_valid}, 8'h00);
        @(posedge clk);
        #1;
        chk("race_rv", {7'd0, res_valid}, 8'h01);
        chk("race_res", res_data, 8'h33);
        chk("race_err_count", err_count, 8'h02);
        @(posedge clk);
        #1;

        // result backpressure
        res_ready = 1'b0;
        send(8'hA0);
        send(8'hFF);
        send(8'h0F);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'hA1;
            in_valid = 1'b1;
            chk("bp_rv", {7'd0, res_valid}, 8'h01);
            chk("bp_rd", res_data, 8'h0F);
            chk("bp_in_ready", {7'd0, in_ready}, 8'h00);
            chk("bp_op", {5'd0, alu_opcode}, 8'h00);
            chk("bp_a", alu_a, 8'hFF);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        chk("bp_rv_hold", {7'd0, res_valid}, 8'h01);
        @(posedge clk);
        #1;
        chk("bp_idle", {7'd0, in_ready}, 8'h01);
        chk("bp_rv_drop", {7'd0, res_valid}, 8'h00);

        // reset mid-frame
        send(8'hA0);
        send(8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_a", alu_a, 8'h00);
        chk("mrst_b", alu_b, 8'h00);
        chk("mrst_op", {5'd0, alu_opcode}, 8'h00);
        chk("mrst_rd", res_data, 8'h00);
        chk("mrst_rv", {7'd0, res_valid}, 8'h00);
        chk("mrst_ec", err_count, 8'h00);
        chk("mrst_ep", {7'd0, err_pulse}, 8'h00);
        chk("mrst_ir", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mrst_quiet_ep", {7'd0, err_pulse}, 8'h00);
            chk("mrst_quiet_rv", {7'd0, res_valid}, 8'h00);
        end

        // saturation
        repeat (255) send(8'h00);
        chk("sat_255", err_count, 8'hFF);
        send(8'h00);
        chk("sat_256", err_count, 8'hFF);
        chk("sat_pulse", {7'd0, err_pulse}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
